// File: rtl/proyecto4_pkg.sv
// proyecto4_pkg: shared width defaults, HALT opcode and fetch FSM encoding.
package proyecto4_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [3:0] OPC_HALT = 4'hF;
  typedef enum logic [1:0] {START, RUN, HALT} state_e;
endpackage

// File: rtl/instr_rom.sv
// instr_rom: synchronous-read instruction ROM with 1-cycle latency.
// Contents come from INIT, a packed hex image with word i at bits [i*DATA_W +: DATA_W].
module instr_rom #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT = '0
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] data_q;
  for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_mem
    assign mem[i] = INIT[i*DATA_W +: DATA_W];
  end
  always_ff @(posedge clk) begin
    if (en_i) data_q <= mem[addr_i];
  end
  assign data_o = data_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with stall, redirect and HALT handling.
// Define FETCH_COUNT_EN to add the 16-bit fetch_count transfer counter output.
module fetch_stage
  import proyecto4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W*(2**ADDR_W)-1:0] ROM_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, opc_q, opc_d;
  logic              vld_q, vld_d;
  logic              load, xfer;
  logic [DATA_W-1:0] rom_data;

  instr_rom #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .INIT  (ROM_INIT)
  ) u_rom (
    .clk   (clk),
    .en_i  (load),
    .addr_i(pc_q),
    .data_o(rom_data)
  );

  assign xfer = vld_q && out_ready;

  // pc_q is the ROM address; in RUN it is always the next word to present
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    opc_d   = opc_q;
    load    = 1'b0;
    if (br_valid) begin
      state_d = RUN;
      pc_d    = br_target;
      vld_d   = 1'b0;
    end else if (state_q == START) begin
      state_d = RUN;
    end else if (state_q == RUN && xfer && rom_data[DATA_W-1 -: 4] == OPC_HALT) begin
      state_d = HALT;
      vld_d   = 1'b0;
    end else if (state_q == RUN && (!vld_q || out_ready)) begin
      load  = 1'b1;
      vld_d = 1'b1;
      opc_d = pc_q;
      pc_d  = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= START;
      pc_q    <= RESET_PC;
      opc_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opc_q   <= opc_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_pc    = opc_q;
  assign out_instr = vld_q ? rom_data : '0;
  assign halted    = state_q == HALT;

`ifdef FETCH_COUNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 16'd1;
  end
  assign fetch_count = cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_fetch_stage;
  function automatic logic [15:0] rom_word(input int a);
    if (a < 4) return 16'((a + 1) * 16'h1111);
    if (a == 5) return 16'hF000;
    return {4'(a % 15), 4'hA, 8'(a)};
  endfunction

  function automatic logic [4095:0] build_img();
    logic [4095:0] v;
    v = '0;
    for (int i = 0; i < 256; i++) v[i*16 +: 16] = rom_word(i);
    return v;
  endfunction

  localparam logic [4095:0] IMG = build_img();

  logic        clk = 1'b0, reset = 1'b0, br_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  br_target = 8'h00;
  logic        out_valid, halted, fe_valid, fe_halted;
  logic [15:0] out_instr, fe_instr;
  logic [7:0]  out_pc, fe_pc;
`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count, fe_count;
`endif
  int tests = 0, fails = 0;

  bit          e_valid, m_halt, m_start;
  logic [7:0]  e_pc, exp_pc;
  logic [15:0] e_instr, m_cnt;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'h00), .ROM_INIT(IMG)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_target(br_target), .out_ready(out_ready),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .halted(halted)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  fetch_stage #(.ADDR_W(8), .DATA_W(16), .RESET_PC(8'hFE), .ROM_INIT(IMG)) dut_fe (
    .clk(clk), .reset(reset), .br_valid(1'b0), .br_target(8'h00), .out_ready(1'b1),
    .out_valid(fe_valid), .out_instr(fe_instr), .out_pc(fe_pc), .halted(fe_halted)
`ifdef FETCH_COUNT_EN
    , .fetch_count(fe_count)
`endif
  );

  // Advance one clock and update the model from the inputs applied before that edge
  task automatic step();
    bit x;
    @(posedge clk); #1;
    x = e_valid && out_ready;
    if (x) m_cnt++;
    if (br_valid) begin
      e_valid = 0; m_halt = 0; m_start = 0; exp_pc = br_target;
    end else if (m_start) begin
      m_start = 0;
    end else if (!m_halt && (!e_valid || out_ready)) begin
      if (x && e_instr[15:12] == 4'hF) begin
        m_halt = 1; e_valid = 0;
      end else begin
        e_valid = 1; e_pc = exp_pc; e_instr = rom_word(int'(exp_pc)); exp_pc++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; br_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    e_valid = 0; m_halt = 0; m_start = 1; exp_pc = 8'h00; m_cnt = '0; e_pc = '0; e_instr = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({out_valid, halted, out_pc, out_instr} !== 26'd0) begin
      fails++; $display("FAIL reset_outputs: got %h want 0", {out_valid, halted, out_pc, out_instr});
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    do_reset();
    step();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL start_bubble: got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 8'(i) || out_instr !== 16'((i + 1) * 16'h1111)) begin
        fails++; $display("FAIL stream_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, out_valid, out_pc, out_instr, 8'(i), 16'((i + 1) * 16'h1111));
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    do_reset();
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 8'h01 || out_instr !== 16'h2222) begin
        fails++; $display("FAIL stall_hold_%0d: got v=%b pc=%h i=%h want v=1 pc=01 i=2222", i, out_valid, out_pc, out_instr);
      end
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h02 || out_instr !== 16'h3333) begin
      fails++; $display("FAIL stall_release: got v=%b pc=%h i=%h want v=1 pc=02 i=3333", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_branch_stall();
    out_ready = 1'b0;
    step();
    br_valid = 1'b1; br_target = 8'h40;
    step();
    br_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL branch_flush: got %b want 0", out_valid); end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h40 || out_instr !== rom_word(8'h40)) begin
      fails++; $display("FAIL branch_target: got v=%b pc=%h i=%h want v=1 pc=40 i=%h", out_valid, out_pc, out_instr, rom_word(8'h40));
    end
  endtask

  task automatic test_halt();
    out_ready = 1'b1; br_valid = 1'b1; br_target = 8'h03;
    step();
    br_valid = 1'b0;
    repeat (3) step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h05 || out_instr !== 16'hF000 || halted !== 1'b0) begin
      fails++; $display("FAIL halt_present: got v=%b pc=%h i=%h h=%b want v=1 pc=05 i=f000 h=0", out_valid, out_pc, out_instr, halted);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      tests++;
      if (out_valid !== 1'b0 || halted !== 1'b1) begin
        fails++; $display("FAIL halt_hold_%0d: got v=%b h=%b want v=0 h=1", i, out_valid, halted);
      end
    end
    br_valid = 1'b1; br_target = 8'h00;
    step();
    br_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || halted !== 1'b0) begin
      fails++; $display("FAIL halt_exit: got v=%b h=%b want v=0 h=0", out_valid, halted);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'h1111) begin
      fails++; $display("FAIL halt_restart: got v=%b pc=%h i=%h want v=1 pc=00 i=1111", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_branch_xfer();
    logic [15:0] c0;
    out_ready = 1'b1;
    step();
    c0 = m_cnt;
    br_valid = 1'b1; br_target = 8'h80;
    step();
    br_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || m_cnt !== c0 + 16'd1) begin
      fails++; $display("FAIL bx_flush: got v=%b cnt=%0d want v=0 cnt=%0d", out_valid, m_cnt, c0 + 16'd1);
    end
`ifdef FETCH_COUNT_EN
    tests++;
    if (fetch_count !== m_cnt) begin fails++; $display("FAIL bx_count: got %0d want %0d", fetch_count, m_cnt); end
`endif
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h80) begin
      fails++; $display("FAIL bx_target: got v=%b pc=%h want v=1 pc=80", out_valid, out_pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    out_ready = 1'b1;
    do_reset();
    step();
    tests++;
    if (fe_valid !== 1'b0) begin fails++; $display("FAIL wrap_bubble: got %b want 0", fe_valid); end
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if (fe_valid !== 1'b1 || fe_pc !== seq[i] || fe_instr !== rom_word(int'(seq[i])) || fe_halted !== 1'b0) begin
        fails++; $display("FAIL wrap_%0d: got v=%b pc=%h i=%h want v=1 pc=%h i=%h", i, fe_valid, fe_pc, fe_instr, seq[i], rom_word(int'(seq[i])));
      end
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b1;
    do_reset();
    repeat (3) step();
    out_ready = 1'b0;
    step();
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({out_valid, halted, out_pc, out_instr} !== 26'd0) begin
      fails++; $display("FAIL async_reset: got %h want 0", {out_valid, halted, out_pc, out_instr});
    end
    out_ready = 1'b1;
    do_reset();
`ifdef FETCH_COUNT_EN
    tests++;
    if (fetch_count !== 16'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
`endif
    step();
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rs_bubble: got %b want 0", out_valid); end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'h1111) begin
      fails++; $display("FAIL rs_first: got v=%b pc=%h i=%h want v=1 pc=00 i=1111", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_random();
    out_ready = 1'b1;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      out_ready = $urandom_range(0, 9) < 7;
      br_valid  = $urandom_range(0, 19) == 0;
      br_target = $urandom_range(0, 1) ? 8'($urandom_range(0, 8)) : 8'($urandom_range(0, 255));
      step();
      tests++;
      if (out_valid !== e_valid || halted !== m_halt || out_instr !== (e_valid ? e_instr : 16'h0) || (e_valid && out_pc !== e_pc)) begin
        fails++; $display("FAIL rand_%0d: got v=%b h=%b pc=%h i=%h want v=%b h=%b pc=%h i=%h", n, out_valid, halted, out_pc, out_instr, e_valid, m_halt, e_pc, e_valid ? e_instr : 16'h0);
      end
`ifdef FETCH_COUNT_EN
      tests++;
      if (fetch_count !== m_cnt) begin fails++; $display("FAIL rand_count_%0d: got %0d want %0d", n, fetch_count, m_cnt); end
`endif
    end
    br_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_stall();
    test_halt();
    test_branch_xfer();
    test_wrap();
    test_reset_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
